// File: rtl/maxnet_pkg.sv
// Shared types and constants for the maxnet controller slice.
package maxnet_pkg;

  localparam int DATA_W_DEFAULT   = 5;
  localparam int NUM_IN           = 4;
  localparam int MAX_ITER_DEFAULT = 15;
  localparam int ITER_W_DEFAULT   = $clog2(MAX_ITER_DEFAULT + 1);

  // Controller states; encoding is visible on the state_o debug port.
  typedef enum logic [2:0] {
    ST_COLLECT = 3'd0,
    ST_LOAD    = 3'd1,
    ST_MUL     = 3'd2,
    ST_UPD     = 3'd3,
    ST_CHECK   = 3'd4,
    ST_CAPTURE = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  // Iteration counter width: wide enough to hold max_iter itself.
  function automatic int iter_width(input int max_iter);
    return $clog2(max_iter + 1);
  endfunction

endpackage

// File: rtl/operand_collector.sv
// Stages four operand words from a valid/ready stream into X1..X4.
// A word transfers on a cycle where x_valid_i and x_ready_i are both high.
module operand_collector
  import maxnet_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] x_i,
  input  logic              x_valid_i,
  input  logic              x_ready_i,
  input  logic              clear_i,
  output logic [DATA_W-1:0] x1_o,
  output logic [DATA_W-1:0] x2_o,
  output logic [DATA_W-1:0] x3_o,
  output logic [DATA_W-1:0] x4_o,
  output logic              done_o
);

  localparam int CNT_W = $clog2(NUM_IN);

  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] x_q [NUM_IN];
  logic              take;

  assign take   = x_valid_i & x_ready_i;
  assign done_o = take & (cnt_q == CNT_W'(NUM_IN - 1));

  assign x1_o = x_q[0];
  assign x2_o = x_q[1];
  assign x3_o = x_q[2];
  assign x4_o = x_q[3];

  // Word counter steers each accepted word into the next slot; it wraps to 0 after the 4th.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      for (int i = 0; i < NUM_IN; i++) x_q[i] <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (take) begin
      x_q[cnt_q] <= x_i;
      cnt_q      <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/maxnet_controller.sv
// Control and input staging for the 4-input winner-take-all datapath.
// Handshakes: a transfer occurs on a rising clk edge where valid and ready are
// both high; once raised, valid and its payload hold until that transfer.
module maxnet_controller
  import maxnet_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int MAX_ITER = MAX_ITER_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] x_in,
  input  logic              x_valid,
  output logic              x_ready,
  output logic [DATA_W-1:0] X1,
  output logic [DATA_W-1:0] X2,
  output logic [DATA_W-1:0] X3,
  output logic [DATA_W-1:0] X4,
  output logic              sel,
  output logic              en0,
  output logic              en1,
  output logic              en2,
  output logic              en3,
  input  logic              complete,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              timeout,
  output logic              busy,
  output logic [2:0]        state_o
);

  localparam int              ITER_W   = iter_width(MAX_ITER);
  localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);

  state_e            state_q;
  logic [ITER_W-1:0] iter_q;
  logic              sel_q;
  logic              en0_q;
  logic              en1_q;
  logic              en2_q;
  logic              en3_q;
  logic              result_valid_q;
  logic              timeout_q;
  logic              busy_q;
  logic              x_ready_q;
  logic              col_done;

  operand_collector #(
    .DATA_W(DATA_W)
  ) u_collector (
    .clk      (clk),
    .rst      (rst),
    .x_i      (x_in),
    .x_valid_i(x_valid),
    .x_ready_i(x_ready_q),
    .clear_i  (~x_ready_q),
    .x1_o     (X1),
    .x2_o     (X2),
    .x3_o     (X3),
    .x4_o     (X4),
    .done_o   (col_done)
  );

  assign x_ready      = x_ready_q;
  assign sel          = sel_q;
  assign en0          = en0_q;
  assign en1          = en1_q;
  assign en2          = en2_q;
  assign en3          = en3_q;
  assign result_valid = result_valid_q;
  assign timeout      = timeout_q;
  assign busy         = busy_q;
  assign state_o      = state_q;

  // Sequencer: every output is registered alongside the state it belongs to,
  // so complete never reaches an output combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_COLLECT;
      iter_q         <= '0;
      sel_q          <= 1'b0;
      en0_q          <= 1'b0;
      en1_q          <= 1'b0;
      en2_q          <= 1'b0;
      en3_q          <= 1'b0;
      result_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      busy_q         <= 1'b0;
      x_ready_q      <= 1'b1;
    end else begin
      // Enables are single-cycle pulses unless the next state re-asserts them.
      en0_q <= 1'b0;
      en1_q <= 1'b0;
      en2_q <= 1'b0;
      en3_q <= 1'b0;
      sel_q <= 1'b0;
      case (state_q)
        ST_COLLECT: begin
          if (col_done) begin
            state_q   <= ST_LOAD;
            en0_q     <= 1'b1;
            x_ready_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        ST_LOAD: begin
          iter_q  <= '0;
          state_q <= ST_MUL;
          en1_q   <= 1'b1;
          sel_q   <= 1'b1;            // iteration counter is 0 entering MUL
        end
        ST_MUL: begin
          state_q <= ST_UPD;
          en2_q   <= 1'b1;
          sel_q   <= (iter_q == '0);
        end
        ST_UPD: begin
          state_q <= ST_CHECK;
          if (iter_q != ITER_MAX) iter_q <= iter_q + ITER_W'(1);
        end
        ST_CHECK: begin
          if (complete) begin
            state_q <= ST_CAPTURE;
            en3_q   <= 1'b1;
          end else if (iter_q == ITER_MAX) begin
            state_q        <= ST_DONE;
            result_valid_q <= 1'b1;
            timeout_q      <= 1'b1;
          end else begin
            state_q <= ST_MUL;
            en1_q   <= 1'b1;
            sel_q   <= (iter_q == '0);
          end
        end
        ST_CAPTURE: begin
          state_q        <= ST_DONE;
          result_valid_q <= 1'b1;
          timeout_q      <= 1'b0;
        end
        ST_DONE: begin
          if (result_ready) begin
            state_q        <= ST_COLLECT;
            result_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
            busy_q         <= 1'b0;
            x_ready_q      <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maxnet_controller.sv
// Directed bench for maxnet_controller with a behavioural maxnet datapath.
module tb_maxnet_controller;

  localparam int W = 5;

  logic clk;
  logic rst;

  // Main instance (MAX_ITER = 15) with the datapath model attached.
  logic [W-1:0] x_in;
  logic         x_valid;
  logic         x_ready;
  logic [W-1:0] X1, X2, X3, X4;
  logic         sel, en0, en1, en2, en3;
  logic         complete;
  logic         result_valid;
  logic         result_ready;
  logic         timeout;
  logic         busy;
  logic [2:0]   st;

  // Second instance (MAX_ITER = 4) with complete tied low.
  logic [W-1:0] x_in2;
  logic         x_valid2;
  logic         x_ready2;
  logic [W-1:0] Y1, Y2, Y3, Y4;
  logic         sel2, f0, f1, f2, f3;
  logic         result_valid2;
  logic         result_ready2;
  logic         timeout2;
  logic         busy2;
  logic [2:0]   st2;

  logic force_c;
  int   checks;
  int   errors;

  maxnet_controller #(.DATA_W(W), .MAX_ITER(15)) dut (
    .clk(clk), .rst(rst), .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready),
    .X1(X1), .X2(X2), .X3(X3), .X4(X4), .sel(sel),
    .en0(en0), .en1(en1), .en2(en2), .en3(en3), .complete(complete),
    .result_valid(result_valid), .result_ready(result_ready),
    .timeout(timeout), .busy(busy), .state_o(st)
  );

  maxnet_controller #(.DATA_W(W), .MAX_ITER(4)) dut_to (
    .clk(clk), .rst(rst), .x_in(x_in2), .x_valid(x_valid2), .x_ready(x_ready2),
    .X1(Y1), .X2(Y2), .X3(Y3), .X4(Y4), .sel(sel2),
    .en0(f0), .en1(f1), .en2(f2), .en3(f3), .complete(1'b0),
    .result_valid(result_valid2), .result_ready(result_ready2),
    .timeout(timeout2), .busy(busy2), .state_o(st2)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- datapath model ----------------
  // a_i' = max(0, a_i - (sum of other a_j) >> 2); winner = single nonzero a.
  logic [W-1:0] dp_x [4];
  logic [W-1:0] dp_a [4];
  logic [W-1:0] dp_p [4];
  logic [W-1:0] dp_res;
  logic         dp_complete;

  function automatic logic [W-1:0] dp_src(input int i);
    return sel ? dp_x[i] : dp_a[i];
  endfunction

  function automatic int dp_win();
    for (int i = 0; i < 4; i++) if (dp_a[i] != 0) return i;
    return 0;
  endfunction

  always_comb begin
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) if (dp_a[i] != 0) n++;
    dp_complete = (n == 1);
  end

  assign complete = force_c | dp_complete;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        dp_x[i] <= '0;
        dp_a[i] <= '0;
        dp_p[i] <= '0;
      end
      dp_res <= '0;
    end else begin
      if (en0) begin
        dp_x[0] <= X1; dp_x[1] <= X2; dp_x[2] <= X3; dp_x[3] <= X4;
      end
      if (en1) begin
        for (int i = 0; i < 4; i++) begin
          int s;
          s = 0;
          for (int j = 0; j < 4; j++) if (j != i) s += int'(dp_src(j));
          dp_p[i] <= W'(s >> 2);
        end
      end
      if (en2) begin
        for (int i = 0; i < 4; i++)
          dp_a[i] <= (dp_src(i) > dp_p[i]) ? dp_src(i) - dp_p[i] : '0;
      end
      if (en3) dp_res <= dp_x[dp_win()];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [W-1:0] d);
    x_in    = d;
    x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
  endtask

  task automatic send_word2(input logic [W-1:0] d);
    x_in2    = d;
    x_valid2 = 1'b1;
    tick();
    x_valid2 = 1'b0;
  endtask

  // Called right after the 4th-transfer edge; counts cycles until result_valid.
  task automatic run_main(output int cyc, output int n_en0, output int n_sel,
                          output int first_sel, output int n_en3, output int n_multi,
                          output logic [2:0] st4);
    cyc = 0; n_en0 = 0; n_sel = 0; first_sel = -1; n_en3 = 0; n_multi = 0; st4 = '0;
    while (!result_valid && cyc < 200) begin
      if (en0) n_en0++;
      if (sel) begin
        n_sel++;
        if (first_sel < 0) first_sel = cyc;
      end
      if (en3) n_en3++;
      if (int'(en0) + int'(en1) + int'(en2) + int'(en3) > 1) n_multi++;
      if (cyc == 4) st4 = st;
      tick();
      cyc++;
    end
  endtask

  task automatic drain_main(input string tag);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check({tag, "_xready"}, x_ready, 1);
    check({tag, "_rv_low"}, result_valid, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc, n_en0, n_sel, first_sel, n_en3, n_multi;
    logic [2:0] st4;
    checks = 0; errors = 0;
    rst = 1'b1; force_c = 1'b0;
    x_in = '0; x_valid = 1'b0; result_ready = 1'b0;
    x_in2 = '0; x_valid2 = 1'b0; result_ready2 = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_state", st, 0);
    check("rst_outs", {x_ready, busy, sel, en0, en1, en2, en3, result_valid, timeout}, 9'b1_0000_0000);
    check("rst_x", {X1, X2, X3, X4}, 0);
    check("rst_to_outs", {x_ready2, busy2, f3, result_valid2, timeout2}, 5'b10000);
    rst = 1'b0;
    tick();

    // Winner 3,10,7,1: datapath needs N=4 -> 14 cycles, result 10
    send_word(5'd3); send_word(5'd10); send_word(5'd7); send_word(5'd1);
    check("win_en0_load", {st, en0, busy, x_ready}, {3'd1, 1'b1, 1'b1, 1'b0});
    run_main(cyc, n_en0, n_sel, first_sel, n_en3, n_multi, st4);
    check("win_latency", cyc, 14);
    check("win_en0_count", n_en0, 1);
    check("win_sel_count", n_sel, 2);
    check("win_sel_first", first_sel, 1);
    check("win_en3_count", n_en3, 1);
    check("win_en_exclusive", n_multi, 0);
    check("win_result", {result_valid, timeout, dp_res}, {1'b1, 1'b0, 5'd10});

    // Result backpressure: hold 6 cycles in DONE
    for (int i = 0; i < 6; i++) begin
      tick();
      check("hold_result", {result_valid, timeout, dp_res, x_ready, busy}, {1'b1, 1'b0, 5'd10, 1'b0, 1'b1});
    end
    drain_main("win");

    // Input backpressure: valid 1,0,1,0,1,1 with words 5,9,2,4
    x_in = 5'd5; x_valid = 1'b1; tick();
    x_in = 5'd31; x_valid = 1'b0; tick();
    x_in = 5'd9; x_valid = 1'b1; tick();
    x_in = 5'd30; x_valid = 1'b0; tick();
    x_in = 5'd2; x_valid = 1'b1; tick();
    x_in = 5'd4; x_valid = 1'b1; tick();
    check("bp_x", {X1, X2, X3, X4}, {5'd5, 5'd9, 5'd2, 5'd4});
    x_in = 5'd17; x_valid = 1'b1;          // offered while busy
    run_main(cyc, n_en0, n_sel, first_sel, n_en3, n_multi, st4);
    check("bp_latency", cyc, 11);
    check("bp_result", {timeout, dp_res}, {1'b0, 5'd9});
    check("bp_not_consumed", {X1, X2, X3, X4}, {5'd5, 5'd9, 5'd2, 5'd4});
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("b2b_ready", {x_ready, busy, X1}, {1'b1, 1'b0, 5'd5});
    tick();
    check("b2b_first_word", X1, 17);
    x_valid = 1'b0;

    // Reset mid-operation: X = 17,20,1,2 runs past iteration 1
    send_word(5'd20); send_word(5'd1); send_word(5'd2);
    for (int i = 0; i < 5; i++) tick();
    check("mid_in_upd2", {st, en2, sel}, {3'd3, 1'b1, 1'b0});
    #2 rst = 1'b1;
    #1;
    check("mid_rst_en", {sel, en0, en1, en2, en3}, 0);
    check("mid_rst_x", {X1, X2, X3, X4}, 0);
    check("mid_rst_hs", {st, x_ready, busy, result_valid}, {3'd0, 1'b1, 1'b0, 1'b0});
    tick();
    rst = 1'b0;
    tick();
    send_word(5'd1); send_word(5'd2); send_word(5'd3); send_word(5'd20);
    run_main(cyc, n_en0, n_sel, first_sel, n_en3, n_multi, st4);
    check("fresh_latency", cyc, 5);
    check("fresh_result", {timeout, dp_res}, {1'b0, 5'd20});
    drain_main("fresh");

    // Immediate complete forced at the first CHECK
    force_c = 1'b1;
    send_word(5'd4); send_word(5'd4); send_word(5'd4); send_word(5'd4);
    run_main(cyc, n_en0, n_sel, first_sel, n_en3, n_multi, st4);
    check("imm_latency", cyc, 5);
    check("imm_capture", st4, 5);
    check("imm_en3_count", n_en3, 1);
    check("imm_timeout", timeout, 0);
    force_c = 1'b0;
    drain_main("imm");

    // Timeout instance: MAX_ITER=4, complete=0 -> 13 cycles, timeout=1, no en3
    send_word2(5'd8); send_word2(5'd8); send_word2(5'd8); send_word2(5'd8);
    cyc = 0; n_en3 = 0;
    while (!result_valid2 && cyc < 200) begin
      if (f3) n_en3++;
      tick();
      cyc++;
    end
    check("to_latency", cyc, 13);
    check("to_flag", {result_valid2, timeout2}, 2'b11);
    check("to_en3_never", n_en3, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("to_hold", {result_valid2, timeout2, f3}, 3'b110);
    end
    result_ready2 = 1'b1;
    tick();
    result_ready2 = 1'b0;
    check("to_release", {x_ready2, result_valid2, timeout2, busy2}, 4'b1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
